// File: rtl/vga_dither_out.sv
// VGA output stage: recovers pixel position from the syncs and reduces IN_BITS colour to OUT_BITS with 4x4 Bayer dithering.
// Optional: define VGA_DITHER_OUT_BLANK_EN to force colour to 0 outside the H/V active window.

module vga_dither_lane #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 4
) (
    input  logic [IN_BITS-1:0]  pix,
    input  logic [3:0]          d,
    output logic [OUT_BITS-1:0] q
);
    localparam int D = IN_BITS - OUT_BITS;

    generate
        if (D == 0) begin : g_pass
            logic unused_d;
            assign unused_d = ^d;
            assign q = pix;
        end else begin : g_dith
            logic [IN_BITS:0] t;
            logic [IN_BITS:0] s;
            logic             unused_lo;
            // Threshold is scaled so its 4 bits sit just below the kept MSBs.
            if (D >= 4) begin : g_shl
                assign t = (IN_BITS+1)'(d) << (D - 4);
            end else begin : g_shr
                assign t = (IN_BITS+1)'(d >> (4 - D));
            end
            assign s         = {1'b0, pix} + t;
            assign q         = s[IN_BITS] ? '1 : s[IN_BITS-1:D];
            assign unused_lo = ^s[D-1:0];
        end
    endgenerate
endmodule

module vga_dither_out #(
    parameter int IN_BITS         = 8,
    parameter int OUT_BITS        = 4,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int H_BACK          = 48,
    parameter int H_ACTIVE        = 640,
    parameter int V_BACK          = 33,
    parameter int V_ACTIVE        = 480,
    parameter int XW              = 11,
    parameter int YW              = 10
) (
    input  logic                CLK_25MHZ,
    input  logic                RESET,
    input  logic                IN_HSYNC,
    input  logic                IN_VSYNC,
    input  logic [IN_BITS-1:0]  IN_RED,
    input  logic [IN_BITS-1:0]  IN_GREEN,
    input  logic [IN_BITS-1:0]  IN_BLUE,
    output logic                VGA_HSYNC,
    output logic                VGA_VSYNC,
    output logic [OUT_BITS-1:0] VGA_RED,
    output logic [OUT_BITS-1:0] VGA_GREEN,
    output logic [OUT_BITS-1:0] VGA_BLUE,
    output logic                FRAME_START
);
    localparam int   NUM_LANES = 3;
    localparam logic INACT     = (SYNC_ACTIVE_LOW != 0);

    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    typedef struct packed {
        logic                               hs;
        logic                               vs;
        logic                               fs;
        logic [NUM_LANES-1:0][IN_BITS-1:0]  rgb;
    } s1_t;

    s1_t                                s1;
    logic [XW-1:0]                      x;
    logic [YW-1:0]                      y;
    logic                               hedge;
    logic                               vedge;
    logic [3:0]                         d;
    logic [NUM_LANES-1:0][OUT_BITS-1:0] dith;
    logic [NUM_LANES-1:0][OUT_BITS-1:0] col;

    // Registered stage-1 syncs double as the previous-sync state, so x/y stay aligned with s1.
    assign hedge = (s1.hs != INACT) && (IN_HSYNC == INACT);
    assign vedge = (s1.vs != INACT) && (IN_VSYNC == INACT);

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            s1 <= '{hs: INACT, vs: INACT, fs: 1'b0, rgb: '0};
            x  <= '0;
            y  <= '0;
        end else begin
            s1.hs  <= IN_HSYNC;
            s1.vs  <= IN_VSYNC;
            s1.fs  <= vedge;
            s1.rgb <= {IN_BLUE, IN_GREEN, IN_RED};
            if (hedge)
                x <= '0;
            else if (!(&x))
                x <= x + 1'b1;
            if (vedge)
                y <= '0;
            else if (hedge && !(&y))
                y <= y + 1'b1;
        end
    end

    assign d = BAYER[{y[1:0], x[1:0]}];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        vga_dither_lane #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_lane (
            .pix (s1.rgb[i]),
            .d   (d),
            .q   (dith[i])
        );
    end

`ifdef VGA_DITHER_OUT_BLANK_EN
    localparam logic [XW:0] X_LO = (XW+1)'(H_BACK);
    localparam logic [XW:0] X_HI = (XW+1)'(H_BACK + H_ACTIVE);
    localparam logic [YW:0] Y_LO = (YW+1)'(V_BACK);
    localparam logic [YW:0] Y_HI = (YW+1)'(V_BACK + V_ACTIVE);
    logic in_win;
    assign in_win = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                    ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
    assign col = in_win ? dith : '0;
`else
    assign col = dith;
`endif

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            VGA_HSYNC   <= INACT;
            VGA_VSYNC   <= INACT;
            VGA_RED     <= '0;
            VGA_GREEN   <= '0;
            VGA_BLUE    <= '0;
            FRAME_START <= 1'b0;
        end else begin
            VGA_HSYNC   <= s1.hs;
            VGA_VSYNC   <= s1.vs;
            VGA_RED     <= col[0];
            VGA_GREEN   <= col[1];
            VGA_BLUE    <= col[2];
            FRAME_START <= s1.fs;
        end
    end
endmodule

// File: tb/tb_vga_dither_out.sv
// Randomized bench for vga_dither_out: default 8->4 instance plus a 4->4 passthrough instance, checked against a position/threshold model.
module tb_vga_dither_out;
    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 4;
    localparam int D        = IN_BITS - OUT_BITS;
    localparam int OMAX     = (1 << OUT_BITS) - 1;
    localparam int XMAX     = 2047;
    localparam int YMAX     = 1023;
    localparam int H_BACK   = 48;
    localparam int H_ACTIVE = 640;
    localparam int V_BACK   = 33;
    localparam int V_ACTIVE = 480;

    logic       clk = 0;
    logic       rst = 1;
    logic       hs = 1, vs = 1;
    logic [7:0] r = 0, g = 0, b = 0;
    logic       o_hs, o_vs, o_fs, p_hs, p_vs, p_fs;
    logic [3:0] o_r, o_g, o_b, p_r, p_g, p_b;

    vga_dither_out dut (
        .CLK_25MHZ(clk), .RESET(rst), .IN_HSYNC(hs), .IN_VSYNC(vs),
        .IN_RED(r), .IN_GREEN(g), .IN_BLUE(b),
        .VGA_HSYNC(o_hs), .VGA_VSYNC(o_vs),
        .VGA_RED(o_r), .VGA_GREEN(o_g), .VGA_BLUE(o_b), .FRAME_START(o_fs)
    );

    vga_dither_out #(.IN_BITS(4), .OUT_BITS(4)) dut_pt (
        .CLK_25MHZ(clk), .RESET(rst), .IN_HSYNC(hs), .IN_VSYNC(vs),
        .IN_RED(r[7:4]), .IN_GREEN(g[7:4]), .IN_BLUE(b[7:4]),
        .VGA_HSYNC(p_hs), .VGA_VSYNC(p_vs),
        .VGA_RED(p_r), .VGA_GREEN(p_g), .VGA_BLUE(p_b), .FRAME_START(p_fs)
    );

    always #20 clk = ~clk;

    typedef struct {
        int hs; int vs; int fs;
        int r;  int g;  int b;
        int pr; int pg; int pb;
    } exp_t;

    int   n_chk = 0;
    int   n_bad = 0;
    int   bayer [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
    exp_t e_rst, e_prev;
    int   mx, my, mhs, mvs;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d x=%0d y=%0d t=%0t", tag, got, exp, mx, my, $time);
        end
    endtask

    function automatic int dith(input int v, input int d);
        int t, q;
        t = (D >= 4) ? (d << (D - 4)) : (d >> (4 - D));
        q = (v + t) >> D;
        return (q > OMAX) ? OMAX : q;
    endfunction

    function automatic bit in_window(input int px, input int py);
`ifdef VGA_DITHER_OUT_BLANK_EN
        return px >= H_BACK && px < H_BACK + H_ACTIVE && py >= V_BACK && py < V_BACK + V_ACTIVE;
`else
        return 1'b1;
`endif
    endfunction

    // One pixel clock: drive, let the edge pass, compare the output that is due, then model this pixel.
    task automatic step(input bit rst_i, input bit h, input bit v,
                        input logic [7:0] ri, input logic [7:0] gi, input logic [7:0] bi);
        exp_t e;
        bit   hedge, vedge, en;
        int   d;
        rst = rst_i; hs = h; vs = v; r = ri; g = gi; b = bi;
        @(posedge clk); #1;
        e = rst_i ? e_rst : e_prev;
        chk("hsync",   o_hs, e.hs);
        chk("vsync",   o_vs, e.vs);
        chk("fstart",  o_fs, e.fs);
        chk("red",     o_r,  e.r);
        chk("green",   o_g,  e.g);
        chk("blue",    o_b,  e.b);
        chk("pt_red",  p_r,  e.pr);
        chk("pt_green", p_g, e.pg);
        chk("pt_blue", p_b,  e.pb);
        chk("pt_fstart", p_fs, e.fs);
        if (rst_i) begin
            mx = 0; my = 0; mhs = 1; mvs = 1;
            e_prev = e_rst;
        end else begin
            hedge = (mhs == 0) && h;
            vedge = (mvs == 0) && v;
            mx = hedge ? 0 : ((mx == XMAX) ? mx : mx + 1);
            if (vedge) my = 0;
            else if (hedge && my < YMAX) my++;
            mhs = h; mvs = v;
            d  = bayer[(my % 4) * 4 + (mx % 4)];
            en = in_window(mx, my);
            e_prev.hs = h;
            e_prev.vs = v;
            e_prev.fs = vedge;
            e_prev.r  = en ? dith(ri, d) : 0;
            e_prev.g  = en ? dith(gi, d) : 0;
            e_prev.b  = en ? dith(bi, d) : 0;
            e_prev.pr = en ? int'(ri >> 4) : 0;
            e_prev.pg = en ? int'(gi >> 4) : 0;
            e_prev.pb = en ? int'(bi >> 4) : 0;
        end
    endtask

    // mode 0: random colour; mode 1: red 0x17, green 0xFF, blue 0x00 held.
    task automatic line(input int len, input bit v, input int mode, input int rst_at);
        logic [7:0] cr, cg, cb;
        for (int c = 0; c < len; c++) begin
            cr = (mode == 1) ? 8'h17 : 8'($urandom);
            cg = (mode == 1) ? 8'hFF : 8'($urandom);
            cb = (mode == 1) ? 8'h00 : 8'($urandom);
            step(c >= rst_at && c < rst_at + 3, c >= 4, v, cr, cg, cb);
        end
    endtask

    task automatic frame(input int nlines, input int len, input int mode);
        for (int l = 0; l < nlines; l++)
            line(len, l >= 2, mode, -10);
    endtask

    initial begin
        e_rst = '{hs: 1, vs: 1, fs: 0, r: 0, g: 0, b: 0, pr: 0, pg: 0, pb: 0};
        e_prev = e_rst;
        mx = 0; my = 0; mhs = 1; mvs = 1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 8'h55, 8'hAA, 8'hFF);
        frame(6, 40, 1);
        frame(6, 40, 0);
        line(400, 1'b1, 0, 304);
        line(40, 1'b1, 0, -10);
        for (int i = 0; i < 500; i++)
            step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        for (int i = 0; i < 2200; i++)
            step(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        frame(36, 760, 0);
        frame(4, 40, 1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
